// File: rtl/mult_hilo_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mult_hilo_sequencer_pkg
// Brief    : Shared encodings for the HI/LO multiply sequencer and pipeline.
// Revision : 1.0 - initial release
// ============================================================================
package mult_hilo_sequencer_pkg;

    typedef logic [1:0] state_t;

    localparam state_t IDLE  = 2'b00;
    localparam state_t RUN   = 2'b01;
    localparam state_t FIXUP = 2'b10;

    localparam logic [3:0] OP_MULT  = 4'b0110;
    localparam logic [3:0] OP_MULTU = 4'b0111;

    localparam logic [1:0] SEL_HI = 2'b01;
    localparam logic [1:0] SEL_LO = 2'b10;

    // Convenience decode for the EX stage: does this regsel read HI or LO?
    function automatic logic reads_hilo(input logic [1:0] regsel);
        return (regsel == SEL_HI) || (regsel == SEL_LO);
    endfunction

    function automatic logic is_mult_op(input logic [3:0] alu_op);
        return (alu_op == OP_MULT) || (alu_op == OP_MULTU);
    endfunction

endpackage
`default_nettype wire

// File: rtl/mult_shift_add_dp.sv
`default_nettype none
// ============================================================================
// Module   : mult_shift_add_dp
// Brief    : Shift-add datapath: magnitude load, multiplier shifter, accumulator.
// Revision : 1.0 - initial release
// ============================================================================
module mult_shift_add_dp #(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic               step,
    input  logic               signed_op,
    input  logic [WIDTH-1:0]   op_a,
    input  logic [WIDTH-1:0]   op_b,
    output logic [2*WIDTH-1:0] acc
);

    logic [WIDTH-1:0]   r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [2*WIDTH-1:0] r_acc;

    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic [WIDTH:0]     w_sum;
    logic [2*WIDTH-1:0] w_acc_next;

    // Magnitudes are unsigned, so |min_int| folds back to itself correctly.
    assign w_mag_a = (signed_op && op_a[WIDTH-1]) ? -op_a : op_a;
    assign w_mag_b = (signed_op && op_b[WIDTH-1]) ? -op_b : op_b;

    // The carry out of the upper half becomes the new MSB after the shift.
    assign w_sum      = {1'b0, r_acc[2*WIDTH-1:WIDTH]}
                      + (r_mplier[0] ? {1'b0, r_mcand} : {(WIDTH+1){1'b0}});
    assign w_acc_next = {w_sum, r_acc[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
        end else if (load) begin
            r_mcand  <= w_mag_a;
            r_mplier <= w_mag_b;
            r_acc    <= '0;
        end else if (step) begin
            r_mplier <= {1'b0, r_mplier[WIDTH-1:1]};
            r_acc    <= w_acc_next;
        end
    end

    assign acc = r_acc;

endmodule
`default_nettype wire

// File: rtl/mult_hilo_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : mult_hilo_sequencer
// Brief    : Iterative MULT/MULTU controller owning the HI/LO register pair.
// Revision : 1.0 - initial release
// ============================================================================
module mult_hilo_sequencer
    import mult_hilo_sequencer_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_op,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             rd_hilo,
    output logic             busy,
    output logic             stall_req,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_neg;
    logic               r_done;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               w_load;
    logic               w_step;
    logic [2*WIDTH-1:0] w_acc;

    mult_shift_add_dp #(
        .WIDTH (WIDTH)
    ) u_dp (
        .clk       (clk),
        .rst       (rst),
        .load      (w_load),
        .step      (w_step),
        .signed_op (signed_op),
        .op_a      (op_a),
        .op_b      (op_b),
        .acc       (w_acc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A start seen while busy is simply not loaded; the stall keeps it in EX.
    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_step      = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_load      = 1'b1;
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                w_step = 1'b1;
                if (r_cnt == '0) begin
                    w_state_nxt = FIXUP;
                end
            end
            FIXUP: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt  <= '0;
            r_neg  <= 1'b0;
            r_done <= 1'b0;
            r_hi   <= '0;
            r_lo   <= '0;
        end else begin
            r_done <= 1'b0;
            if (w_load) begin
                r_cnt <= CNT_W'(WIDTH - 1);
                r_neg <= signed_op & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
            end else if (w_step && (r_cnt != '0)) begin
                r_cnt <= r_cnt - 1'b1;
            end
            // HI/LO have exactly one write path besides reset.
            if (r_state == FIXUP) begin
                {r_hi, r_lo} <= r_neg ? -w_acc : w_acc;
                r_done       <= 1'b1;
            end
        end
    end

    assign busy      = (r_state != IDLE);
    assign stall_req = busy & (start | rd_hilo);
    assign done      = r_done;
    assign hi        = r_hi;
    assign lo        = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_mult_hilo_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_mult_hilo_sequencer
// Brief    : Directed self-checking bench for the HI/LO multiply sequencer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mult_hilo_sequencer;

    localparam int WIDTH = 32;
    localparam int CNT_W = 5;

    logic             clk;
    logic             rst;
    logic             start;
    logic             signed_op;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             rd_hilo;
    logic             busy;
    logic             stall_req;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    int n_checks = 0;
    int n_pass   = 0;

    mult_hilo_sequencer #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .signed_op (signed_op),
        .op_a      (op_a),
        .op_b      (op_b),
        .rd_hilo   (rd_hilo),
        .busy      (busy),
        .stall_req (stall_req),
        .done      (done),
        .hi        (hi),
        .lo        (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one active edge and settle outputs.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one multiply, sampled at the next edge (edge k); then measure how
    // many further edges pass before done and check the result.
    task automatic run_mult(input string tag, input logic sgn,
                            input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                            input logic [WIDTH-1:0] exp_hi, input logic [WIDTH-1:0] exp_lo);
        int lat;
        start = 1'b1; signed_op = sgn; op_a = a; op_b = b;
        tick();
        start = 1'b0; op_a = '0; op_b = '0;
        check({tag, "_busy_after_k"}, 64'(busy), 64'd1);
        lat = 1;
        tick();
        while (!done && lat < 100) begin
            tick();
            lat++;
        end
        check({tag, "_latency"}, 64'(lat), 64'(WIDTH + 1));
        check({tag, "_hi"}, 64'(hi), 64'(exp_hi));
        check({tag, "_lo"}, 64'(lo), 64'(exp_lo));
        check({tag, "_busy_in_done"}, 64'(busy), 64'd0);
        tick();
        check({tag, "_done_pulse"}, 64'(done), 64'd0);
    endtask

    initial begin
        int stall_misses;
        int guard;
        int done_seen;

        rst = 1'b1; start = 1'b0; signed_op = 1'b0;
        op_a = '0; op_b = '0; rd_hilo = 1'b0;
        tick();
        tick();
        check("rst_hi", 64'(hi), 64'd0);
        check("rst_lo", 64'(lo), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        rst = 1'b0;
        tick();

        rd_hilo = 1'b1;
        #1;
        check("idle_rd_no_stall", 64'(stall_req), 64'd0);
        rd_hilo = 1'b0;

        run_mult("multu_3x5", 1'b0, 32'd3, 32'd5, 32'h0000_0000, 32'h0000_000F);
        run_mult("mult_m2x3", 1'b1, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
        run_mult("multu_ffxff", 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        run_mult("mult_ffxff", 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001);
        run_mult("mult_minxmin", 1'b1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
        run_mult("mult_m7xm6", 1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFA, 32'h0000_0000, 32'h0000_002A);

        // rd_hilo two cycles after start must stall until the done cycle.
        start = 1'b1; signed_op = 1'b0; op_a = 32'd6; op_b = 32'd7;
        tick();
        start = 1'b0;
        tick();
        tick();
        rd_hilo = 1'b1;
        #1;
        stall_misses = 0;
        guard = 0;
        while (!done && guard < 100) begin
            if (!stall_req) stall_misses++;
            tick();
            guard++;
        end
        check("rd_stall_held", 64'(stall_misses), 64'd0);
        check("rd_done_seen", 64'(done), 64'd1);
        check("rd_done_no_stall", 64'(stall_req), 64'd0);
        check("rd_done_lo", 64'(lo), 64'h2A);
        rd_hilo = 1'b0;
        tick();

        // A start held while busy is accepted only on the done cycle.
        start = 1'b1; signed_op = 1'b0; op_a = 32'h10; op_b = 32'h10;
        tick();
        op_a = 32'd2; op_b = 32'd3;
        #1;
        check("st2_stall", 64'(stall_req), 64'd1);
        stall_misses = 0;
        guard = 0;
        while (!done && guard < 100) begin
            if (!stall_req) stall_misses++;
            tick();
            guard++;
        end
        check("st2_stall_held", 64'(stall_misses), 64'd0);
        check("st2_first_lo", 64'(lo), 64'h100);
        check("st2_done_no_stall", 64'(stall_req), 64'd0);
        tick();
        start = 1'b0;
        #1;
        check("st2_busy_again", 64'(busy), 64'd1);
        check("st2_lo_kept", 64'(lo), 64'h100);
        guard = 0;
        while (!done && guard < 100) begin
            tick();
            guard++;
        end
        check("st2_second_lo", 64'(lo), 64'd6);
        tick();

        // Reset in the middle of a multiply clears HI/LO and never pulses done.
        run_mult("multu_prior", 1'b0, 32'h1234_5678, 32'h0001_0000, 32'h0000_1234, 32'h5678_0000);
        start = 1'b1; signed_op = 1'b0; op_a = 32'd7; op_b = 32'd9;
        tick();
        start = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_hi", 64'(hi), 64'd0);
        check("abort_lo", 64'(lo), 64'd0);
        done_seen = 0;
        for (int i = 0; i < 40; i++) begin
            if (done) done_seen++;
            tick();
        end
        check("abort_no_done", 64'(done_seen), 64'd0);
        run_mult("multu_7x9", 1'b0, 32'd7, 32'd9, 32'h0000_0000, 32'h0000_003F);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
